// File: rtl/aor3000_pc_pkg.sv
// Shared types and helpers for the R3000 fetch-address sequencer.
package aor3000_pc_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_PEND  = 2'd1,
        EXC_PEND = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC00000;
    localparam int          MAX_ADDR_W           = 64;

    // Clears the low 'bits' address bits; callers narrow the result to their width.
    function automatic logic [MAX_ADDR_W-1:0] align_addr(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int bits);
        logic [MAX_ADDR_W-1:0] mask;
        mask = '1;
        mask = mask << bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/aor3000_pc_trace_buf.sv
// Circular history of applied redirect targets; entry 0 on the read side is the newest.
module aor3000_pc_trace_buf #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  rd_ptr;

    // Storage is deliberately left out of reset; only the count qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (count != (IDX_W+1)'(DEPTH)) begin
                count <= count + (IDX_W+1)'(1);
            end
        end
    end

    assign rd_ptr  = wr_ptr - IDX_W'(1) - rd_idx;
    assign rd_addr = ({1'b0, rd_idx} < count) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/aor3000_pc_sequencer.sv
// Fetch PC / register-fetch PC sequencer with exception and branch redirect arbitration.
// Optional redirect trace buffer is built when AOR3000_PC_TRACE_EN is defined.
module aor3000_pc_sequencer
    import aor3000_pc_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          PC_INC       = 4,
    parameter int          ALIGN_BITS   = 2,
    parameter int          TRACE_DEPTH  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_advance,
    input  logic                             i_branch_valid,
    input  logic [ADDR_W-1:0]                i_branch_target,
    input  logic                             i_exc_valid,
    input  logic [ADDR_W-1:0]                i_exc_vector,
    output logic [ADDR_W-1:0]                o_fetch_pc,
    output logic [ADDR_W-1:0]                o_rf_pc,
    output logic                             o_kill,
    output logic                             o_redirect_pending,
    output logic                             o_in_delay_slot,
    output logic                             o_branch_overrun,
    output logic                             o_misalign,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   i_trace_idx,
    output logic [ADDR_W-1:0]                o_trace_addr,
    output logic [$clog2(TRACE_DEPTH):0]     o_trace_count
);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VECTOR);

    function automatic logic [ADDR_W-1:0] fit(input logic [ADDR_W-1:0] a);
        return ADDR_W'(align_addr(MAX_ADDR_W'(a), ALIGN_BITS));
    endfunction

    pc_state_e         state;
    logic [ADDR_W-1:0] pend_target;
    logic              take_exc;
    logic              take_br;
    logic [ADDR_W-1:0] new_target;
    logic              new_misalign;
    logic              redirect_now;
    logic [ADDR_W-1:0] redirect_target;

    // A branch arriving while an exception waits loses to it outright.
    assign take_exc        = i_exc_valid;
    assign take_br         = i_branch_valid && !i_exc_valid && (state != EXC_PEND);
    assign new_target      = i_exc_valid ? fit(i_exc_vector) : fit(i_branch_target);
    assign new_misalign    = i_exc_valid ? (fit(i_exc_vector) != i_exc_vector)
                                         : (take_br && (fit(i_branch_target) != i_branch_target));
    assign redirect_now    = take_exc || take_br || (state != RUN);
    assign redirect_target = (take_exc || take_br) ? new_target : pend_target;

    assign o_redirect_pending = (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= RUN;
            pend_target      <= '0;
            o_fetch_pc       <= RST_PC;
            o_rf_pc          <= '0;
            o_kill           <= 1'b0;
            o_in_delay_slot  <= 1'b0;
            o_branch_overrun <= 1'b0;
            o_misalign       <= 1'b0;
        end else begin
            o_kill           <= 1'b0;
            o_in_delay_slot  <= 1'b0;
            o_branch_overrun <= 1'b0;
            o_misalign       <= new_misalign;

            if (i_advance) begin
                if (redirect_now) begin
                    o_fetch_pc <= redirect_target;
                    o_rf_pc    <= redirect_target;
                end else begin
                    o_rf_pc    <= o_fetch_pc;
                    o_fetch_pc <= o_fetch_pc + ADDR_W'(PC_INC);
                end
            end

            if (take_exc) begin
                if (i_advance) begin
                    state  <= RUN;
                    o_kill <= 1'b1;
                end else begin
                    state       <= EXC_PEND;
                    pend_target <= new_target;
                end
            end else if (take_br) begin
                if (i_advance) begin
                    state           <= RUN;
                    o_kill          <= 1'b1;
                    o_in_delay_slot <= 1'b1;
                end else begin
                    o_branch_overrun <= (state == BR_PEND);
                    state            <= BR_PEND;
                    pend_target      <= new_target;
                end
            end else if (i_advance && (state != RUN)) begin
                // A latched branch's delay slot is already in flight, so only exceptions kill.
                o_kill          <= (state == EXC_PEND);
                o_in_delay_slot <= (state == BR_PEND);
                state           <= RUN;
            end
        end
    end

`ifdef AOR3000_PC_TRACE_EN
    aor3000_pc_trace_buf #(
        .ADDR_W (ADDR_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (i_advance && redirect_now),
        .push_addr (redirect_target),
        .rd_idx    (i_trace_idx),
        .rd_addr   (o_trace_addr),
        .count     (o_trace_count)
    );
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^i_trace_idx;
    assign o_trace_addr     = '0;
    assign o_trace_count    = '0;
`endif

endmodule

// File: tb/tb_aor3000_pc_sequencer.sv
// Directed and randomized bench for aor3000_pc_sequencer against a behavioural redirect model.
module tb_aor3000_pc_sequencer;
    localparam int DEPTH = 8;
`ifdef AOR3000_PC_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif
    localparam int K_NONE = 0;
    localparam int K_BR   = 1;
    localparam int K_EXC  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        advance, br_valid, exc_valid;
    logic [31:0] br_target, exc_vector;
    logic [2:0]  trace_idx;
    logic [31:0] fetch_pc, rf_pc, trace_addr;
    logic        kill, pending, delay_slot, overrun, misalign;
    logic [3:0]  trace_count;

    logic        adv16;
    logic [15:0] fetch16, rf16, taddr16;
    logic        kill16, pend16, ds16, over16, mis16;
    logic [3:0]  tcount16;

    aor3000_pc_sequencer #(.ADDR_W(32), .TRACE_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_advance(advance),
        .i_branch_valid(br_valid), .i_branch_target(br_target),
        .i_exc_valid(exc_valid), .i_exc_vector(exc_vector),
        .o_fetch_pc(fetch_pc), .o_rf_pc(rf_pc), .o_kill(kill),
        .o_redirect_pending(pending), .o_in_delay_slot(delay_slot),
        .o_branch_overrun(overrun), .o_misalign(misalign),
        .i_trace_idx(trace_idx), .o_trace_addr(trace_addr), .o_trace_count(trace_count)
    );

    aor3000_pc_sequencer #(.ADDR_W(16), .RESET_VECTOR(32'h0000FFF0), .TRACE_DEPTH(DEPTH)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .i_advance(adv16),
        .i_branch_valid(1'b0), .i_branch_target(16'h0000),
        .i_exc_valid(1'b0), .i_exc_vector(16'h0000),
        .o_fetch_pc(fetch16), .o_rf_pc(rf16), .o_kill(kill16),
        .o_redirect_pending(pend16), .o_in_delay_slot(ds16),
        .o_branch_overrun(over16), .o_misalign(mis16),
        .i_trace_idx(3'd0), .o_trace_addr(taddr16), .o_trace_count(tcount16)
    );

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: architectural PCs, the one waiting redirect, and the redirect history.
    logic [31:0] m_fetch, m_rf, m_pend;
    int          m_kind;
    bit          m_kill, m_ds, m_over, m_mis;
    logic [31:0] tq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic model_reset();
        m_fetch = 32'hBFC00000;
        m_rf    = '0;
        m_pend  = '0;
        m_kind  = K_NONE;
        m_kill  = 0;
        m_ds    = 0;
        m_over  = 0;
        m_mis   = 0;
        tq.delete();
    endtask

    task automatic model_step(input bit adv, input bit bv, input logic [31:0] bt,
                              input bit ev, input logic [31:0] vec);
        int          req;
        logic [31:0] req_t;
        logic [31:0] dest;
        bit          jump;
        req   = ev ? K_EXC : ((bv && m_kind != K_EXC) ? K_BR : K_NONE);
        req_t = (req == K_EXC) ? vec : bt;
        dest  = '0;
        jump  = 0;
        m_mis  = (req != K_NONE) && (req_t[1:0] != 2'b00);
        m_over = (req == K_BR) && !adv && (m_kind == K_BR);
        m_kill = 0;
        m_ds   = 0;
        if (!adv) begin
            if (req != K_NONE) begin
                m_kind = req;
                m_pend = word_align(req_t);
            end
        end else begin
            if (req != K_NONE) begin
                dest = word_align(req_t); jump = 1; m_kill = 1; m_ds = (req == K_BR);
            end else if (m_kind != K_NONE) begin
                dest = m_pend; jump = 1; m_kill = (m_kind == K_EXC); m_ds = (m_kind == K_BR);
            end
            m_kind = K_NONE;
            if (jump) begin
                m_rf    = dest;
                m_fetch = dest;
                tq.push_front(dest);
                if (tq.size() > DEPTH) void'(tq.pop_back());
            end else begin
                m_rf    = m_fetch;
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ea;
        int          ec;
        ec = TRACE_ON ? tq.size() : 0;
        ea = '0;
        if (TRACE_ON && int'(trace_idx) < tq.size()) ea = tq[trace_idx];
        chk({tag, ".fetch_pc"}, 64'(fetch_pc), 64'(m_fetch));
        chk({tag, ".rf_pc"}, 64'(rf_pc), 64'(m_rf));
        chk({tag, ".kill"}, 64'(kill), 64'(m_kill));
        chk({tag, ".pending"}, 64'(pending), 64'(m_kind != K_NONE));
        chk({tag, ".delay_slot"}, 64'(delay_slot), 64'(m_ds));
        chk({tag, ".overrun"}, 64'(overrun), 64'(m_over));
        chk({tag, ".misalign"}, 64'(misalign), 64'(m_mis));
        chk({tag, ".trace_count"}, 64'(trace_count), 64'(ec));
        chk({tag, ".trace_addr"}, 64'(trace_addr), 64'(ea));
    endtask

    task automatic step(input bit adv, input bit bv, input logic [31:0] bt,
                        input bit ev, input logic [31:0] vec, input string tag);
        advance    = adv;
        br_valid   = bv;
        br_target  = bt;
        exc_valid  = ev;
        exc_vector = vec;
        trace_idx  = 3'($urandom_range(0, 7));
        @(posedge clk);
        model_step(adv, bv, bt, ev, vec);
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] t;
        rst_n = 1'b0; advance = 0; br_valid = 0; exc_valid = 0; adv16 = 0;
        br_target = '0; exc_vector = '0; trace_idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.fetch_pc", 64'(fetch_pc), 64'h0000_0000_BFC0_0000);
        chk("rst.rf_pc", 64'(rf_pc), 64'h0);
        chk("rst.flags", 64'({kill, pending, delay_slot, overrun, misalign}), 64'h0);
        chk("rst.trace_count", 64'(trace_count), 64'h0);
        rst_n = 1'b1;
        check_all("rst");

        repeat (3) step(1, 0, 0, 0, 0, "seq");
        chk("seq.fetch_pc", 64'(fetch_pc), 64'hBFC0000C);
        chk("seq.rf_pc", 64'(rf_pc), 64'hBFC00008);
        chk("seq.kill", 64'(kill), 64'h0);

        step(0, 1, 32'h80001000, 0, 0, "br_latch");
        chk("br_latch.pending", 64'(pending), 64'h1);
        repeat (2) begin
            step(0, 0, 0, 0, 0, "br_idle");
            chk("br_idle.pending", 64'(pending), 64'h1);
        end
        step(1, 0, 0, 0, 0, "br_apply");
        chk("br_apply.fetch_pc", 64'(fetch_pc), 64'h80001000);
        chk("br_apply.kill", 64'(kill), 64'h0);
        chk("br_apply.delay_slot", 64'(delay_slot), 64'h1);
        step(1, 0, 0, 0, 0, "br_after");
        chk("br_after.delay_slot", 64'(delay_slot), 64'h0);
        chk("br_after.fetch_pc", 64'(fetch_pc), 64'h80001004);

        step(1, 1, 32'h80002000, 1, 32'h80000080, "exc_win");
        chk("exc_win.fetch_pc", 64'(fetch_pc), 64'h80000080);
        chk("exc_win.kill", 64'(kill), 64'h1);
        chk("exc_win.pending", 64'(pending), 64'h0);
        step(0, 0, 0, 0, 0, "exc_win_next");
        chk("exc_win_next.kill", 64'(kill), 64'h0);

        step(0, 1, 32'h80003000, 0, 0, "discard_br");
        step(0, 0, 0, 1, 32'h80000080, "discard_exc");
        chk("discard_exc.pending", 64'(pending), 64'h1);
        step(1, 0, 0, 0, 0, "discard_apply");
        chk("discard_apply.fetch_pc", 64'(fetch_pc), 64'h80000080);
        chk("discard_apply.kill", 64'(kill), 64'h1);
        step(1, 0, 0, 0, 0, "discard_seq");
        chk("discard_seq.fetch_pc", 64'(fetch_pc), 64'h80000084);

        step(0, 1, 32'hA0000000, 0, 0, "ovr_first");
        chk("ovr_first.overrun", 64'(overrun), 64'h0);
        step(0, 1, 32'hA0000010, 0, 0, "ovr_second");
        chk("ovr_second.overrun", 64'(overrun), 64'h1);
        step(1, 0, 0, 0, 0, "ovr_apply");
        chk("ovr_apply.fetch_pc", 64'(fetch_pc), 64'hA0000010);
        chk("ovr_apply.overrun", 64'(overrun), 64'h0);

        step(1, 1, 32'h80004003, 0, 0, "misalign");
        chk("misalign.fetch_pc", 64'(fetch_pc), 64'h80004000);
        chk("misalign.flag", 64'(misalign), 64'h1);
        step(1, 0, 0, 0, 0, "misalign_clear");
        chk("misalign_clear.flag", 64'(misalign), 64'h0);

        for (int i = 0; i < 10; i++) begin
            step(1, 1, 32'h90000000 + 32'(i * 16), 0, 0, "trace_fill");
        end
        chk("trace.count", 64'(trace_count), TRACE_ON ? 64'd8 : 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            trace_idx = 3'(i);
            #1;
            chk("trace.sweep", 64'(trace_addr),
                TRACE_ON ? 64'(32'h90000090 - 32'(i * 16)) : 64'd0);
        end

        for (int n = 0; n < 400; n++) begin
            t = $urandom();
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0), t,
                 ($urandom_range(0, 9) == 0), {$urandom() & 32'hFFFF_FFFC} | 32'(t[1:0]), "rand");
        end

        step(0, 1, 32'h80005000, 0, 0, "midrst_latch");
        chk("midrst_latch.pending", 64'(pending), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.pending", 64'(pending), 64'h0);
        chk("midrst.fetch_pc", 64'(fetch_pc), 64'hBFC00000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 0, 0, 0, 0, "midrst_adv");
        chk("midrst_adv.fetch_pc", 64'(fetch_pc), 64'hBFC00004);

        chk("wrap.reset_pc", 64'(fetch16), 64'hFFF0);
        adv16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("wrap.before", 64'(fetch16), 64'hFFFC);
        @(posedge clk);
        #1;
        adv16 = 1'b0;
        chk("wrap.fetch_pc", 64'(fetch16), 64'h0000);
        chk("wrap.rf_pc", 64'(rf16), 64'hFFFC);
        chk("wrap.kill", 64'({kill16, pend16, ds16, over16, mis16}), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
